// File: rtl/core_pkg.sv
// Shared definitions for the memory access path of the multi-cycle core.
// Holds the load/store size encodings, the memory handshake FSM state type,
// the reset instruction value, error cause codes and a misalignment helper.
package core_pkg;

    // funct3 access size / sign encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Memory handshake FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    // err_cause codes
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    // True when the low address bits do not match the natural alignment of
    // the access size in funct3[1:0] (byte accesses are never misaligned).
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic mis;
        case (f3[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the memory bus.
// Store side: generates byte enables and replicates right-aligned store data
// across the lanes. Load side: extracts the addressed byte/halfword from a
// bus word and sign- or zero-extends it.
// Ports:
//   st_size    in  2   access size (funct3[1:0]) of the store being issued
//   st_addr_lo in  2   byte offset of the store
//   st_data    in  32  right-aligned store data
//   st_be      out 4   byte enables
//   st_wdata   out 32  lane-replicated store data
//   ld_funct3  in  3   load size/sign
//   ld_addr_lo in  2   byte offset of the load
//   ld_word    in  32  word returned by the bus
//   ld_result  out 32  extracted and extended load value
module lsu_align
    import core_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_result
);

    logic [31:0] ld_shift_s;

    // Store lanes: replicating the data lets the byte enables alone pick the lane
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (st_size)
            2'b00: begin
                st_be    = 4'b0001 << st_addr_lo;
                st_wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << st_addr_lo;
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = st_data;
            end
        endcase
    end

    assign ld_shift_s = ld_word >> {ld_addr_lo, 3'b000};

    // Load extract: addressed lane is moved to bit 0, then extended
    always_comb begin
        ld_result = ld_word;
        case (ld_funct3)
            F3_B:    ld_result = {{24{ld_shift_s[7]}}, ld_shift_s[7:0]};
            F3_BU:   ld_result = {24'h00_0000, ld_shift_s[7:0]};
            F3_H:    ld_result = {{16{ld_shift_s[15]}}, ld_shift_s[15:0]};
            F3_HU:   ld_result = {16'h0000, ld_shift_s[15:0]};
            default: ld_result = ld_word;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-side handshake engine for the multi-cycle core.
// Detects the rising edge of the fetch and memory-access phases, issues one
// bus transaction per phase and stalls the phase generator (memWait) until
// the bus acknowledges or a timeout expires. Load data is aligned/extended,
// store data is lane-shifted. Misaligned accesses are rejected without a bus
// transaction and reported through err/err_cause.
// Ports:
//   CLK, RST_N                 clock, synchronous active-low reset
//   ft_phase, ma_phase, ma_en  phase levels from the phase generator
//   rwmem, funct3, pc, ma_addr, st_data   access description
//   mem_req/we/addr/be/wdata   bus request side (registered)
//   mem_ack, mem_rdata         bus completion side
//   memWait                    stall to the phase generator
//   instr, ld_data             fetched instruction / load result (held)
//   err, err_cause             error pulse and held cause code
module mem_access_ctrl
    import core_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ft_phase,
    input  logic              ma_phase,
    input  logic              ma_en,
    input  logic              rwmem,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] ma_addr,
    input  logic [31:0]       st_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              memWait,
    output logic [31:0]       instr,
    output logic [31:0]       ld_data,
    output logic              err,
    output logic [1:0]        err_cause
);

    localparam logic [9:0] TO_LIM = 10'(TIMEOUT);

    mem_state_t  state_r;
    logic        ft_phase_q_r;
    logic        ma_phase_q_r;
    logic        ft_armed_r;
    logic        ma_armed_r;
    logic        mem_req_r;
    logic [9:0]  wait_cnt_r;
    logic        is_fetch_r;
    logic        timed_out_r;
    logic [2:0]  funct3_r;
    logic [1:0]  addr_lo_r;
    logic [31:0] rdata_r;

    logic        idle_s;
    logic        ft_start_s;
    logic        ma_start_s;
    logic        ft_mis_s;
    logic        ma_mis_s;
    logic        ft_go_s;
    logic        ma_go_s;
    logic        mis_err_s;
    logic [3:0]  st_be_s;
    logic [31:0] st_wdata_s;
    logic [31:0] ld_result_s;

    // The armed bits only set once a phase has been seen low after reset, so
    // a phase that is already high when reset releases cannot look like an edge.
    assign idle_s     = (state_r == IDLE);
    assign ft_start_s = ft_phase & ~ft_phase_q_r & ft_armed_r;
    assign ma_start_s = ma_phase & ma_en & ~ma_phase_q_r & ma_armed_r & ~ft_start_s;
    assign ft_mis_s   = (pc[1:0] != 2'b00);
    assign ma_mis_s   = is_misaligned(funct3, ma_addr[1:0]);
    assign ft_go_s    = ft_start_s & ~ft_mis_s;
    assign ma_go_s    = ma_start_s & ~ma_mis_s;
    assign mis_err_s  = idle_s & ((ft_start_s & ft_mis_s) | (ma_start_s & ma_mis_s));

    // Reset must drop the stall and the request in the cycle it is asserted
    assign memWait = RST_N & (ft_go_s | ma_go_s | ~idle_s);
    assign mem_req = RST_N & mem_req_r;

    lsu_align u_lsu_align (
        .st_size    (funct3[1:0]),
        .st_addr_lo (ma_addr[1:0]),
        .st_data    (st_data),
        .st_be      (st_be_s),
        .st_wdata   (st_wdata_s),
        .ld_funct3  (funct3_r),
        .ld_addr_lo (addr_lo_r),
        .ld_word    (rdata_r),
        .ld_result  (ld_result_s)
    );

    // Handshake FSM with all bus and result outputs registered
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r      <= IDLE;
            ft_phase_q_r <= 1'b0;
            ma_phase_q_r <= 1'b0;
            ft_armed_r   <= 1'b0;
            ma_armed_r   <= 1'b0;
            mem_req_r    <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_be       <= 4'b0000;
            mem_wdata    <= 32'h0000_0000;
            wait_cnt_r   <= 10'd0;
            is_fetch_r   <= 1'b0;
            timed_out_r  <= 1'b0;
            funct3_r     <= 3'b000;
            addr_lo_r    <= 2'b00;
            rdata_r      <= 32'h0000_0000;
            instr        <= NOP;
            ld_data      <= 32'h0000_0000;
            err          <= 1'b0;
            err_cause    <= ERR_NONE;
        end else begin
            ft_phase_q_r <= ft_phase;
            ma_phase_q_r <= ma_phase;
            ft_armed_r   <= ft_armed_r | ~ft_phase;
            ma_armed_r   <= ma_armed_r | ~ma_phase;
            err          <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (ft_go_s) begin
                        state_r     <= REQ;
                        mem_req_r   <= 1'b1;
                        mem_we      <= 1'b0;
                        mem_addr    <= {pc[ADDR_W-1:2], 2'b00};
                        mem_be      <= 4'b1111;
                        mem_wdata   <= 32'h0000_0000;
                        is_fetch_r  <= 1'b1;
                        funct3_r    <= F3_W;
                        addr_lo_r   <= 2'b00;
                        wait_cnt_r  <= 10'd0;
                        timed_out_r <= 1'b0;
                    end else if (ma_go_s) begin
                        state_r     <= REQ;
                        mem_req_r   <= 1'b1;
                        mem_we      <= rwmem;
                        mem_addr    <= {ma_addr[ADDR_W-1:2], 2'b00};
                        mem_be      <= rwmem ? st_be_s : 4'b1111;
                        mem_wdata   <= rwmem ? st_wdata_s : 32'h0000_0000;
                        is_fetch_r  <= 1'b0;
                        funct3_r    <= funct3;
                        addr_lo_r   <= ma_addr[1:0];
                        wait_cnt_r  <= 10'd0;
                        timed_out_r <= 1'b0;
                    end else if (mis_err_s) begin
                        err       <= 1'b1;
                        err_cause <= ERR_MISALIGN;
                    end
                end
                REQ: begin
                    mem_req_r <= 1'b0;
                    if (mem_ack) begin
                        rdata_r <= mem_rdata;
                        state_r <= DONE;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        rdata_r <= mem_rdata;
                        state_r <= DONE;
                    end else if (wait_cnt_r >= TO_LIM - 10'd1) begin
                        // This is the TIMEOUT-th silent WAIT cycle
                        timed_out_r <= 1'b1;
                        err         <= 1'b1;
                        err_cause   <= ERR_TIMEOUT;
                        state_r     <= DONE;
                    end else if (wait_cnt_r != TO_LIM) begin
                        wait_cnt_r <= wait_cnt_r + 10'd1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    if (!timed_out_r) begin
                        if (is_fetch_r) begin
                            instr <= rdata_r;
                        end else if (!mem_we) begin
                            ld_data <= ld_result_s;
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
    import core_pkg::*;

    localparam int AW = 32;
    localparam int TO = 8;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        ft_phase = 1'b0, ma_phase = 1'b0, ma_en = 1'b0, rwmem = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] pc = 32'h0, ma_addr = 32'h0, st_data = 32'h0, mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, memWait, err;
    logic [31:0] mem_addr, mem_wdata, instr, ld_data;
    logic [3:0]  mem_be;
    logic [1:0]  err_cause;

    mem_access_ctrl #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST_N(RST_N), .ft_phase(ft_phase), .ma_phase(ma_phase),
        .ma_en(ma_en), .rwmem(rwmem), .funct3(funct3), .pc(pc), .ma_addr(ma_addr),
        .st_data(st_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .memWait(memWait), .instr(instr), .ld_data(ld_data),
        .err(err), .err_cause(err_cause)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Model expectations for the current cycle
    logic        chk_en = 1'b0;
    logic        e_wait = 1'b0, e_req = 1'b0, e_err = 1'b0, e_we = 1'b0;
    logic [1:0]  e_cause = 2'b00;
    logic [31:0] e_instr = NOP, e_ld = 32'h0, e_addr = 32'h0, e_wdata = 32'h0;
    logic [3:0]  e_be = 4'h0;

    int          wait_seen = 0;
    int          req_seen = 0;
    logic        cap_we;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, sampled away from the active edge
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("memWait", {31'b0, memWait}, {31'b0, e_wait});
            chk("mem_req", {31'b0, mem_req}, {31'b0, e_req});
            chk("err", {31'b0, err}, {31'b0, e_err});
            chk("err_cause", {30'b0, err_cause}, {30'b0, e_cause});
            chk("instr", instr, e_instr);
            chk("ld_data", ld_data, e_ld);
            if (e_req) begin
                chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_be", {28'b0, mem_be}, {28'b0, e_be});
                chk("mem_wdata", mem_wdata, e_wdata);
            end
            if (memWait) wait_seen++;
            if (mem_req) begin
                req_seen++;
                cap_we    <= mem_we;
                cap_addr  <= mem_addr;
                cap_be    <= mem_be;
                cap_wdata <= mem_wdata;
            end
        end
    end

    function automatic int size_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        else if (f3[1:0] == 2'b01) return 2;
        else return 4;
    endfunction

    function automatic logic [31:0] load_model(input logic [31:0] rd, input int a, input logic [2:0] f3);
        int          sz;
        logic [63:0] mask;
        logic [31:0] v;
        sz = size_bytes(f3);
        v  = rd >> (8 * a);
        if (sz == 4) return v;
        mask = (64'd1 << (8 * sz)) - 64'd1;
        v = v & mask[31:0];
        if (!f3[2] && v[8 * sz - 1]) v = v | ~mask[31:0];
        return v;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            ft_phase = 1'b0; ma_phase = 1'b0; ma_en = 1'b0; mem_ack = 1'b0;
            e_wait = 1'b0; e_req = 1'b0; e_err = 1'b0;
        end
    endtask

    // One phase-triggered access; ack_dly = cycles from mem_req to mem_ack, <0 = never
    task automatic txn(input bit is_ft, input logic [31:0] addr, input logic [2:0] f3,
                       input bit we, input logic [31:0] sd, input logic [31:0] rd,
                       input int ack_dly);
        int         sz, a, L, ncyc;
        bit         mis, tmo, wr;
        logic [7:0] be8;
        sz   = is_ft ? 4 : size_bytes(f3);
        a    = int'(addr[1:0]);
        mis  = (addr % sz) != 0;
        tmo  = !mis && (ack_dly < 0);
        wr   = !is_ft && we;
        L    = mis ? 0 : (tmo ? TO + 3 : 3 + ack_dly);
        ncyc = ((L > 2) ? L : 2) + 1;
        be8  = ((8'd1 << sz) - 8'd1) << a;
        e_we   = wr;
        e_addr = addr & 32'hFFFF_FFFC;
        e_be   = wr ? be8[3:0] : 4'hF;
        e_wdata = 32'h0;
        if (wr) for (int i = 0; i < 4; i++) e_wdata[8*i +: 8] = sd[8*(i % sz) +: 8];
        wait_seen = 0;
        req_seen  = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge CLK); #1;
            if (c == 0) begin
                if (is_ft) begin
                    pc = addr; ft_phase = 1'b1;
                end else begin
                    ma_addr = addr; funct3 = f3; rwmem = we; st_data = sd;
                    ma_phase = 1'b1; ma_en = 1'b1;
                end
            end
            if (c == ncyc - 1) begin
                ft_phase = 1'b0; ma_phase = 1'b0; ma_en = 1'b0;
            end
            mem_ack   = !mis && (ack_dly >= 0) && (c == 1 + ack_dly);
            mem_rdata = mem_ack ? rd : $urandom;
            if (c == L && L > 0 && !tmo) begin
                if (is_ft) e_instr = rd;
                else if (!we) e_ld = load_model(rd, a, f3);
            end
            e_wait = (c < L);
            e_req  = !mis && (c == 1);
            e_err  = mis ? (c == 1) : (tmo && (c == TO + 2));
            if (e_err) e_cause = mis ? ERR_MISALIGN : ERR_TIMEOUT;
        end
    endtask

    // Fetch without ack, RST_N pulsed low in cycle rc, late ack afterwards
    task automatic reset_txn(input int rc);
        e_we = 1'b0; e_addr = 32'h500; e_be = 4'hF; e_wdata = 32'h0;
        wait_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge CLK); #1;
            if (c == rc + 1) begin
                e_instr = NOP; e_ld = 32'h0; e_cause = 2'b00;
            end
            RST_N = (c == rc) ? 1'b0 : 1'b1;
            if (c == 0) begin pc = 32'h500; ft_phase = 1'b1; end
            if (c == 8) ft_phase = 1'b0;
            mem_ack   = (c == rc + 2);
            mem_rdata = 32'hDEAD_BEEF;
            e_wait = (c < rc);
            e_req  = (c == 1) && (rc != 1);
            e_err  = 1'b0;
        end
    endtask

    logic [2:0] f3_tab [5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};

    initial begin
        int          kind, dly;
        logic [31:0] addr;
        logic [2:0]  f3;
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        chk_en = 1'b1;
        @(negedge CLK);
        chk("reset instr", instr, 32'h0000_0013);
        chk("reset mem_req", {31'b0, mem_req}, 32'h0);
        chk("reset mem_addr", mem_addr, 32'h0);
        idle(2);

        // Fetch, ack two cycles after the request
        txn(1'b1, 32'h100, F3_W, 1'b0, 32'h0, 32'h0050_0093, 2);
        chk("fetch wait cycles", wait_seen, 32'd5);
        chk("fetch instr", instr, 32'h0050_0093);
        chk("fetch addr", cap_addr, 32'h100);
        chk("fetch we", {31'b0, cap_we}, 32'h0);
        idle(1);

        // Zero-wait fetch: minimum stall
        txn(1'b1, 32'h104, F3_W, 1'b0, 32'h0, 32'h1234_5678, 0);
        chk("zero-wait cycles", wait_seen, 32'd3);

        txn(1'b0, 32'h203, F3_B, 1'b0, 32'h0, 32'h80FF_1234, 1);
        chk("LB ld_data", ld_data, 32'hFFFF_FF80);
        chk("LB be", {28'b0, cap_be}, 32'hF);
        txn(1'b0, 32'h203, F3_BU, 1'b0, 32'h0, 32'h80FF_1234, 0);
        chk("LBU ld_data", ld_data, 32'h0000_0080);

        txn(1'b0, 32'h302, F3_H, 1'b1, 32'h0000_ABCD, 32'h0, 1);
        chk("SH we", {31'b0, cap_we}, 32'h1);
        chk("SH addr", cap_addr, 32'h300);
        chk("SH be", {28'b0, cap_be}, 32'hC);
        chk("SH wdata", cap_wdata, 32'hABCD_ABCD);

        txn(1'b0, 32'h401, F3_W, 1'b0, 32'h0, 32'h0, 0);
        chk("misalign wait cycles", wait_seen, 32'd0);
        chk("misalign no req", req_seen, 32'd0);
        chk("misalign cause", {30'b0, err_cause}, 32'h1);
        chk("misalign ld held", ld_data, 32'h0000_0080);

        txn(1'b1, 32'h108, F3_W, 1'b0, 32'h0, 32'h0, -1);
        chk("timeout req pulses", req_seen, 32'd1);
        chk("timeout wait cycles", wait_seen, 32'd11);
        chk("timeout instr held", instr, 32'h1234_5678);
        chk("timeout cause", {30'b0, err_cause}, 32'h2);

        reset_txn(3);
        reset_txn(1);
        txn(1'b1, 32'h600, F3_W, 1'b0, 32'h0, 32'hCAFE_0001, 1);
        chk("post-reset fetch", instr, 32'hCAFE_0001);

        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 2);
            addr = $urandom;
            if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
            dly = ($urandom_range(0, 15) == 0) ? -1 : $urandom_range(0, 4);
            if (kind == 2) f3 = f3_tab[$urandom_range(0, 2)];
            else f3 = f3_tab[$urandom_range(0, 4)];
            txn(kind == 0, addr, f3, kind == 2, $urandom, $urandom, dly);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
